// File: rtl/conv1d_ctrl_pkg.sv
// Shared types and constants for the conv1d job sequencer.
// The descriptor struct lets the control-register block hand over a job as one bundle.
package conv1d_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_MAX_K  = 8;
  localparam int unsigned DEF_LEN_W  = 12;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StAcc,
    StWrite,
    StDone
  } state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] in_base;
    logic [DEF_ADDR_W-1:0] w_base;
    logic [DEF_ADDR_W-1:0] out_base;
    logic [DEF_LEN_W-1:0]  in_len;
    logic [DEF_LEN_W-1:0]  k_len;
  } job_desc_t;

endpackage

// File: rtl/conv1d_mac.sv
// Signed 16x16 multiply feeding a 32-bit accumulator that wraps modulo 2^32.
// clear_i has priority over en_i.
module conv1d_mac (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic signed [15:0] a_i,
  input  logic signed [15:0] b_i,
  output logic [31:0]        acc_o
);

  logic signed [31:0] prod;
  logic [31:0]        acc_q;

  assign prod  = a_i * b_i;
  assign acc_o = acc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + prod;
    end
  end

endmodule

// File: rtl/conv1d_ctrl.sv
// Job sequencer: loads the kernel, runs a valid-mode 1D convolution over SRAM through a
// single-outstanding request/grant/rvalid port, writes results back and pulses done.
module conv1d_ctrl
  import conv1d_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned MAX_K  = DEF_MAX_K,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] in_base_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] out_base_i,
  input  logic [LEN_W-1:0]  in_len_i,
  input  logic [LEN_W-1:0]  k_len_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  n_out_o,
  output logic              done_int_o
);

  localparam int unsigned KIDX_W = (MAX_K > 1) ? $clog2(MAX_K) : 1;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  idx);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'(idx) * ADDR_W'(WORD_BYTES);
    return (base & ~ADDR_W'(WORD_BYTES - 1)) + off;
  endfunction

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [LEN_W-1:0]  n_out_q, n_out_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] w_base_q, w_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [LEN_W-1:0]  in_len_q, in_len_d;
  logic [LEN_W-1:0]  k_len_q, k_len_d;
  logic [15:0]       w_q [MAX_K];
  logic [15:0]       w_d [MAX_K];

  logic        rsp;
  logic        job_bad;
  logic        mac_clear;
  logic        mac_en;
  logic [31:0] acc;
  logic        unused_rdata_hi;

  // Only a response to our own pending transaction counts; strays are dropped.
  assign rsp     = pend_q & mem_rvalid_i;
  assign job_bad = (k_len_i == '0) || (k_len_i > LEN_W'(MAX_K)) || (in_len_i < k_len_i);
  assign unused_rdata_hi = ^mem_rdata_i[31:16];

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    pend_d     = pend_q;
    addr_d     = addr_q;
    k_d        = k_q;
    n_d        = n_q;
    n_out_d    = n_out_q;
    err_d      = err_q;
    in_base_d  = in_base_q;
    w_base_d   = w_base_q;
    out_base_d = out_base_q;
    in_len_d   = in_len_q;
    k_len_d    = k_len_q;
    w_d        = w_q;
    mac_clear  = 1'b0;
    mac_en     = 1'b0;

    if (req_q && mem_gnt_i) begin
      req_d  = 1'b0;
      pend_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          in_base_d  = in_base_i;
          w_base_d   = w_base_i;
          out_base_d = out_base_i;
          in_len_d   = in_len_i;
          k_len_d    = k_len_i;
          if (job_bad) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            n_out_d = '0;
            k_d     = '0;
            n_d     = '0;
            req_d   = 1'b1;
            addr_d  = word_addr(w_base_i, '0);
            state_d = StLoadW;
          end
        end
      end
      StLoadW: begin
        if (rsp) begin
          pend_d                 = 1'b0;
          req_d                  = 1'b1;
          w_d[k_q[KIDX_W-1:0]]   = mem_rdata_i[15:0];
          if (k_q == k_len_q - LEN_W'(1)) begin
            k_d       = '0;
            mac_clear = 1'b1;
            addr_d    = word_addr(in_base_q, n_q);
            state_d   = StAcc;
          end else begin
            k_d    = k_q + LEN_W'(1);
            addr_d = word_addr(w_base_q, k_q + LEN_W'(1));
          end
        end
      end
      StAcc: begin
        if (rsp) begin
          pend_d = 1'b0;
          req_d  = 1'b1;
          mac_en = 1'b1;
          if (k_q == k_len_q - LEN_W'(1)) begin
            k_d     = '0;
            addr_d  = word_addr(out_base_q, n_q);
            state_d = StWrite;
          end else begin
            k_d    = k_q + LEN_W'(1);
            addr_d = word_addr(in_base_q, n_q + k_q + LEN_W'(1));
          end
        end
      end
      StWrite: begin
        if (rsp) begin
          pend_d  = 1'b0;
          n_out_d = n_out_q + LEN_W'(1);
          if (n_q == in_len_q - k_len_q) begin
            state_d = StDone;
          end else begin
            n_d       = n_q + LEN_W'(1);
            mac_clear = 1'b1;
            req_d     = 1'b1;
            addr_d    = word_addr(in_base_q, n_q + LEN_W'(1));
            state_d   = StAcc;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      pend_q     <= 1'b0;
      addr_q     <= '0;
      k_q        <= '0;
      n_q        <= '0;
      n_out_q    <= '0;
      err_q      <= 1'b0;
      in_base_q  <= '0;
      w_base_q   <= '0;
      out_base_q <= '0;
      in_len_q   <= '0;
      k_len_q    <= '0;
      for (int i = 0; i < MAX_K; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      k_q        <= k_d;
      n_q        <= n_d;
      n_out_q    <= n_out_d;
      err_q      <= err_d;
      in_base_q  <= in_base_d;
      w_base_q   <= w_base_d;
      out_base_q <= out_base_d;
      in_len_q   <= in_len_d;
      k_len_q    <= k_len_d;
      w_q        <= w_d;
    end
  end

  conv1d_mac u_mac (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (mac_clear),
    .en_i    (mac_en),
    .a_i     (mem_rdata_i[15:0]),
    .b_i     (w_q[k_q[KIDX_W-1:0]]),
    .acc_o   (acc)
  );

  assign mem_req_o   = req_q;
  assign mem_we_o    = (state_q == StWrite);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = (state_q == StWrite) ? acc : 32'h0;
  assign busy_o      = (state_q != StIdle);
  assign err_o       = err_q;
  assign n_out_o     = n_out_q;
  assign done_int_o  = (state_q == StDone);

endmodule

// File: tb/tb_conv1d_ctrl.sv
// Directed bench for conv1d_ctrl: SRAM responder with programmable grant/rvalid delays
// that also watches request stability and the single-outstanding rule.
module tb_conv1d_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in_base, w_base, out_base;
  logic [11:0] in_len, k_len;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, err, done_int;
  logic [11:0] n_out;

  logic [31:0] mem [1024];
  int gnt_delay = 0, rv_delay = 1;
  int txn_count = 0, req_cycles = 0, done_cnt = 0, proto_err = 0;
  int stray_req = 0, stray_done = 0;
  int checks = 0, errors = 0;

  // Responder-private state
  int          wait_cnt = 0, rsp_cnt = 0;
  bit          rsp_pending = 0;
  logic [31:0] rsp_data, h_addr, h_wdata;
  logic        h_we;

  always #5 clk = ~clk;

  conv1d_ctrl #(
    .ADDR_W (32),
    .MAX_K  (8),
    .LEN_W  (12)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .in_base_i    (in_base),
    .w_base_i     (w_base),
    .out_base_i   (out_base),
    .in_len_i     (in_len),
    .k_len_i      (k_len),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .busy_o       (busy),
    .err_o        (err),
    .n_out_o      (n_out),
    .done_int_o   (done_int)
  );

  // SRAM responder, evaluated on the falling edge
  initial begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (rst) begin
        wait_cnt    = 0;
        rsp_pending = 0;
      end else begin
        if (done_int) done_cnt++;
        if (mem_req) req_cycles++;
        if (stray_req != stray_done) begin
          stray_done = stray_req;
          mem_rvalid = 1'b1;
          mem_rdata  = 32'hBAD0BAD0;
        end else if (rsp_pending) begin
          rsp_cnt--;
          if (rsp_cnt == 0) begin
            mem_rvalid  = 1'b1;
            mem_rdata   = rsp_data;
            rsp_pending = 0;
          end
        end
        if (mem_req) begin
          if (rsp_pending || mem_rvalid) proto_err++;
          if (wait_cnt == 0) begin
            h_addr  = mem_addr;
            h_we    = mem_we;
            h_wdata = mem_wdata;
          end else if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata) begin
            proto_err++;
          end
          if (wait_cnt == gnt_delay) begin
            mem_gnt  = 1'b1;
            wait_cnt = 0;
            txn_count++;
            if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
            else rsp_data = mem[mem_addr[11:2]];
            rsp_pending = 1;
            rsp_cnt     = rv_delay;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [31:0] ib, input logic [31:0] wb, input logic [31:0] ob,
                           input logic [11:0] l, input logic [11:0] k);
    in_base  = ib;
    w_base   = wb;
    out_base = ob;
    in_len   = l;
    k_len    = k;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done_int) seen = 1;
      else tick();
    end
    check(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic error_job(input string tag, input logic [11:0] l, input logic [11:0] k);
    int r0, t0;
    r0 = req_cycles;
    t0 = txn_count;
    start_job(32'h100, 32'h200, 32'h3C0, l, k);
    check({tag, "_done"}, {31'd0, done_int}, 32'd1);
    check({tag, "_err"}, {31'd0, err}, 32'd1);
    tick();
    check({tag, "_done_low"}, {31'd0, done_int}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    tick();
    check({tag, "_no_req"}, req_cycles - r0, 32'd0);
    check({tag, "_no_txn"}, txn_count - t0, 32'd0);
    check({tag, "_nout_kept"}, {20'd0, n_out}, 32'd1);
  endtask

  int d0, t0, r0;
  bit found;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst = 1'b1; start = 1'b0;
    in_base = '0; w_base = '0; out_base = '0; in_len = '0; k_len = '0;
    tick(); tick();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_outs", {28'd0, mem_we, busy, err, done_int}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_nout", {20'd0, n_out}, 32'd0);
    rst = 1'b0;
    tick();

    // Job 1: in=[1..5], w=[1,0,-1], every output -2
    for (int i = 0; i < 5; i++) mem[32'h40 + i] = 32'(i + 1);
    mem[32'h80] = 32'h1; mem[32'h81] = 32'h0; mem[32'h82] = 32'hFFFFFFFF;
    d0 = done_cnt; t0 = txn_count;
    start_job(32'h100, 32'h200, 32'h300, 12'd5, 12'd3);
    check("t1_first_req", {31'd0, mem_req}, 32'd1);
    check("t1_first_addr", mem_addr, 32'h200);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done("t1_done", 300);
    tick(); tick();
    check("t1_out0", mem[32'hC0], 32'hFFFFFFFE);
    check("t1_out1", mem[32'hC1], 32'hFFFFFFFE);
    check("t1_out2", mem[32'hC2], 32'hFFFFFFFE);
    check("t1_txn", txn_count - t0, 32'd15);
    check("t1_nout", {20'd0, n_out}, 32'd3);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_pulses", done_cnt - d0, 32'd1);

    // Job 2: four products of (-32768)^2 wrap to zero; upper halves must be ignored
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + i] = 32'h12348000;
      mem[32'h140 + i] = 32'hFFFF8000;
    end
    mem[32'h180] = 32'hDEADBEEF;
    t0 = txn_count;
    start_job(32'h400, 32'h500, 32'h600, 12'd4, 12'd4);
    wait_done("t2_done", 300);
    tick(); tick();
    check("t2_out", mem[32'h180], 32'h0);
    check("t2_txn", txn_count - t0, 32'd9);
    check("t2_nout", {20'd0, n_out}, 32'd1);

    error_job("k0", 12'd5, 12'd0);
    error_job("k9", 12'd12, 12'd9);
    error_job("l_lt_k", 12'd2, 12'd3);

    // Backpressure with unaligned bases; valid start also clears err
    gnt_delay = 3; rv_delay = 2;
    t0 = txn_count; d0 = done_cnt;
    start_job(32'h101, 32'h202, 32'h343, 12'd5, 12'd3);
    check("bp_err_cleared", {31'd0, err}, 32'd0);
    check("bp_nout_cleared", {20'd0, n_out}, 32'd0);
    wait_done("bp_done", 1000);
    tick(); tick();
    check("bp_out0", mem[32'hD0], 32'hFFFFFFFE);
    check("bp_out1", mem[32'hD1], 32'hFFFFFFFE);
    check("bp_out2", mem[32'hD2], 32'hFFFFFFFE);
    check("bp_txn", txn_count - t0, 32'd15);
    check("bp_nout", {20'd0, n_out}, 32'd3);
    check("bp_pulses", done_cnt - d0, 32'd1);

    // Second start while in ACC must be ignored
    gnt_delay = 0; rv_delay = 1;
    t0 = txn_count; d0 = done_cnt;
    start_job(32'h100, 32'h200, 32'h380, 12'd5, 12'd3);
    for (int i = 0; i < 8; i++) tick();
    check("t6_in_acc", {31'd0, busy}, 32'd1);
    start_job(32'h000, 32'h040, 32'h3C0, 12'd7, 12'd0);
    wait_done("t6_done", 300);
    tick(); tick(); tick();
    check("t6_out0", mem[32'hE0], 32'hFFFFFFFE);
    check("t6_out2", mem[32'hE2], 32'hFFFFFFFE);
    check("t6_txn", txn_count - t0, 32'd15);
    check("t6_err", {31'd0, err}, 32'd0);
    check("t6_pulses", done_cnt - d0, 32'd1);

    // Reset while an ACC read request is waiting for grant
    gnt_delay = 3; rv_delay = 2;
    start_job(32'h100, 32'h200, 32'h300, 12'd5, 12'd3);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (mem_req && !mem_we && mem_addr >= 32'h100 && mem_addr < 32'h114) found = 1;
      else tick();
    end
    check("t7_acc_req", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    check("t7_req", {31'd0, mem_req}, 32'd0);
    check("t7_outs", {28'd0, mem_we, busy, err, done_int}, 32'd0);
    check("t7_addr", mem_addr, 32'd0);
    check("t7_nout", {20'd0, n_out}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    r0 = req_cycles;
    stray_req++;
    for (int i = 0; i < 8; i++) tick();
    check("t7_no_req", req_cycles - r0, 32'd0);
    check("t7_idle", {31'd0, busy}, 32'd0);
    check("t7_proto", proto_err, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
